sync_tx: RTL and testbench

SYNC_TX -- requirements
Module: sync_tx

---
 rtl/sync_pkg.sv | 34 +++
 rtl/sync_tx_nrzi.sv | 67 ++++++
 rtl/sync_tx.sv | 153 +++++++++++++++
 tb/tb_sync_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared types and constants for the SYNC/NRZI line transmitter.
// Latency: n/a (package only).
// Backpressure: n/a. SYNC_TX_BITSTUFF_EN adds the STUFF state.
package sync_pkg;

  localparam int SYNC_LEN_DEF = 8;

  // Line symbols encoded as {k, j}; k=j=1 is never driven.
  localparam logic [1:0] SYM_K   = 2'b10;
  localparam logic [1:0] SYM_J   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  // Run length of payload 1s that forces a stuffed toggle.
  localparam logic [2:0] STUFF_RUN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
`ifdef SYNC_TX_BITSTUFF_EN
    ST_STUFF,
`endif
    ST_EOP_SE0,
    ST_EOP_J
  } state_e;

  // SYNC pattern: K,J alternating from K, with the final two symbols both K.
  function automatic logic [1:0] sync_sym(input int idx, input int len);
    logic [31:0] iv;
    iv = idx;
    return ((iv[0] == 1'b0) || (idx == len - 1)) ? SYM_K : SYM_J;
  endfunction

endpackage

// File: rtl/sync_tx_nrzi.sv
// NRZI encoder with optional bit stuffing (SYNC_TX_BITSTUFF_EN).
// Latency: combinational next level; level register updates on the consuming edge.
// Backpressure: stall=1 means the next symbol is a stuffed toggle and bit_dat is not consumed.
module sync_tx_nrzi import sync_pkg::*; (
  input  logic CLK,
  input  logic RST,
  input  logic init,
  input  logic bit_vld,
  input  logic bit_dat,
  output logic lvl_k,
  output logic stall
);

  logic lvl_q, lvl_d, base_lvl;
`ifdef SYNC_TX_BITSTUFF_EN
  logic [2:0] ones_q, ones_d, base_ones;
`endif

  // Next line level: a 0 toggles, a 1 holds; init restarts from K.
  always_comb begin
    base_lvl = init ? 1'b1 : lvl_q;
    lvl_d    = base_lvl;
`ifdef SYNC_TX_BITSTUFF_EN
    base_ones = init ? 3'd0 : ones_q;
    ones_d    = base_ones;
    if (bit_vld) begin
      if (!init && (ones_q == STUFF_RUN)) begin
        lvl_d  = ~base_lvl;
        ones_d = 3'd0;
      end else if (bit_dat) begin
        ones_d = base_ones + 3'd1;
      end else begin
        lvl_d  = ~base_lvl;
        ones_d = 3'd0;
      end
    end
`else
    if (bit_vld && !bit_dat) begin
      lvl_d = ~base_lvl;
    end
`endif
  end

  assign lvl_k = lvl_d;

`ifdef SYNC_TX_BITSTUFF_EN
  assign stall = (ones_q == STUFF_RUN);
`else
  assign stall = 1'b0;
`endif

  // Level (and run counter) registers; reset parks the line at K.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lvl_q  <= 1'b1;
`ifdef SYNC_TX_BITSTUFF_EN
      ones_q <= 3'd0;
`endif
    end else begin
      lvl_q  <= lvl_d;
`ifdef SYNC_TX_BITSTUFF_EN
      ones_q <= ones_d;
`endif
    end
  end

endmodule

// File: rtl/sync_tx.sv
// Frame transmitter: SYNC, NRZI payload byte (optional stuffing via SYNC_TX_BITSTUFF_EN), EOP.
// Latency: first SYNC symbol on the line one edge after in_start is accepted in IDLE.
// Backpressure: none; in_start is ignored while busy, out_done pulses on return to IDLE.
module sync_tx import sync_pkg::*; #(
  parameter int SYNC_LEN = SYNC_LEN_DEF  // even, >= 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_start,
  input  logic [7:0] in_data,
  output logic       out_k,
  output logic       out_j,
  output logic       out_en,
  output logic       out_busy,
  output logic       out_done
);

  localparam int IDX_W = (SYNC_LEN > 8) ? $clog2(SYNC_LEN) : 3;
  localparam logic [IDX_W-1:0] LAST_SYNC = IDX_W'(SYNC_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(7);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
  logic [7:0]       data_q, data_d;
  logic [1:0]       sym_q, sym_d;
  logic             en_q, en_d, busy_q, busy_d, done_q, done_d;

  logic nz_init, nz_vld, nz_bit, nz_lvl_k, nz_stall;

  sync_tx_nrzi u_nrzi (
    .CLK     (CLK),
    .RST     (RST),
    .init    (nz_init),
    .bit_vld (nz_vld),
    .bit_dat (nz_bit),
    .lvl_k   (nz_lvl_k),
    .stall   (nz_stall)
  );

  // Frame sequencing: next state, symbol/bit index and encoder requests.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    nz_init = 1'b0;
    nz_vld  = 1'b0;
    nz_bit  = 1'b0;
    nxt_idx = idx_q + IDX_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          state_d = ST_SYNC;
          idx_d   = '0;
          data_d  = in_data;
        end
      end
      ST_SYNC: begin
        if (idx_q == LAST_SYNC) begin
          state_d = ST_DATA;
          idx_d   = '0;
          nz_init = 1'b1;
          nz_vld  = 1'b1;
          nz_bit  = data_q[0];
        end else begin
          idx_d = nxt_idx;
        end
      end
`ifdef SYNC_TX_BITSTUFF_EN
      ST_DATA, ST_STUFF: begin
`else
      ST_DATA: begin
`endif
        if (nz_stall) begin
`ifdef SYNC_TX_BITSTUFF_EN
          // Sixth consecutive 1 just went out: insert a toggle, keep the bit index.
          state_d = ST_STUFF;
          nz_vld  = 1'b1;
`endif
        end else if (idx_q == LAST_BIT) begin
          state_d = ST_EOP_SE0;
          idx_d   = '0;
        end else begin
          state_d = ST_DATA;
          idx_d   = nxt_idx;
          nz_vld  = 1'b1;
          nz_bit  = data_q[nxt_idx[2:0]];
        end
      end
      ST_EOP_SE0: begin
        if (idx_q == IDX_W'(1)) begin
          state_d = ST_EOP_J;
          idx_d   = '0;
        end else begin
          idx_d = nxt_idx;
        end
      end
      ST_EOP_J: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Line outputs are a function of the state being entered, so they register alongside it.
  always_comb begin
    sym_d  = SYM_J;
    en_d   = 1'b1;
    busy_d = 1'b1;
    done_d = (state_q == ST_EOP_J);
    case (state_d)
      ST_IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
      end
      ST_SYNC:    sym_d = sync_sym(int'(idx_d), SYNC_LEN);
      ST_EOP_SE0: sym_d = SYM_SE0;
      ST_EOP_J:   sym_d = SYM_J;
      default:    sym_d = nz_lvl_k ? SYM_K : SYM_J;
    endcase
  end

  // State and output registers; reset drops any frame and parks the line idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      sym_q   <= SYM_J;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sym_q   <= sym_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_k    = sym_q[1];
  assign out_j    = sym_q[0];
  assign out_en   = en_q;
  assign out_busy = busy_q;
  assign out_done = done_q;

endmodule

// File: tb/tb_sync_tx.sv
`timescale 1ns/1ps
module tb_sync_tx;

  localparam int SL = 8;

  typedef struct packed {
    logic en;
    logic k;
    logic j;
    logic busy;
    logic done;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_k, out_j, out_en, out_busy, out_done;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always #5 CLK = ~CLK;

  sync_tx #(.SYNC_LEN(SL)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_start (in_start),
    .in_data  (in_data),
    .out_k    (out_k),
    .out_j    (out_j),
    .out_en   (out_en),
    .out_busy (out_busy),
    .out_done (out_done)
  );

  function automatic obs_t mk(input logic en, input logic k, input logic j,
                              input logic busy, input logic done);
    return {en, k, j, busy, done};
  endfunction

  function automatic obs_t cur();
    return {out_en, out_k, out_j, out_busy, out_done};
  endfunction

  // Reference frame: SYNC, NRZI payload LSB first from K, optional stuffing, EOP, done.
  task automatic push_frame(input logic [7:0] d);
    logic lvl;
    int   ones;
    for (int i = 0; i < SL; i++) begin
      if ((i % 2 == 0) || (i == SL - 1)) sb.push_back(mk(1, 1, 0, 1, 0));
      else                               sb.push_back(mk(1, 0, 1, 1, 0));
    end
    lvl  = 1'b1;
    ones = 0;
    for (int b = 0; b < 8; b++) begin
      if (d[b]) ones++;
      else begin
        lvl  = ~lvl;
        ones = 0;
      end
      sb.push_back(mk(1, lvl, ~lvl, 1, 0));
`ifdef SYNC_TX_BITSTUFF_EN
      if (ones == 6) begin
        lvl  = ~lvl;
        ones = 0;
        sb.push_back(mk(1, lvl, ~lvl, 1, 0));
      end
`endif
    end
    sb.push_back(mk(1, 0, 0, 1, 0));
    sb.push_back(mk(1, 0, 0, 1, 0));
    sb.push_back(mk(1, 0, 1, 1, 0));
    sb.push_back(mk(0, 0, 1, 0, 1));
  endtask

  // Monitor: pops one expected line state per cycle, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      if (out_busy) busy_cnt++;
      if (out_done) done_cnt++;
      checks++;
      assert ((out_k & out_j) === 1'b0) else begin
        errors++;
        $error("FAIL k_and_j observed k=%b j=%b required not both 1", out_k, out_j);
      end
      if (sb.size() > 0) begin
        obs_t e;
        e = sb.pop_front();
        checks++;
        assert (cur() === e) else begin
          errors++;
          $error("FAIL line {en,k,j,busy,done} observed=%b expected=%b", cur(), e);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    checks++;
    assert (cur() === mk(0, 0, 1, 0, 0)) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, cur(), mk(0, 0, 1, 0, 0));
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until every expected symbol has been compared; leaves time at posedge+2.
  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge CLK);
      n++;
    end
    check_int({tag, "_drain_left"}, sb.size(), 0);
    if (sb.size() > 0) sb.delete();
    #2;
  endtask

  // Called at posedge+2 with the DUT idle: one-cycle start pulse.
  task automatic start_frame(input logic [7:0] d, input int extra_idle);
    in_data  = d;
    in_start = 1'b1;
    busy_cnt = 0;
    sb.push_back(mk(0, 0, 1, 0, 0));
    push_frame(d);
    for (int i = 0; i < extra_idle; i++) sb.push_back(mk(0, 0, 1, 0, 0));
    @(posedge CLK);
    #2;
    in_start = 1'b0;
  endtask

  int exp_ff, exp_fc;

  initial begin
`ifdef SYNC_TX_BITSTUFF_EN
    exp_ff = SL + 8 + 3 + 1;
    exp_fc = SL + 8 + 3 + 1;
`else
    exp_ff = SL + 8 + 3;
    exp_fc = SL + 8 + 3;
`endif
    // Reset asserted between clock edges: outputs must go idle at once.
    #2 RST = 1'b0;
    #1 check_idle("reset_async");
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    check_idle("after_release");

    // All-zero payload: toggle every bit.
    start_frame(8'h00, 0);
    wait_drain("f00");
    check_int("busy_f00", busy_cnt, SL + 8 + 3);

    // All-ones payload: held level, stuffed toggle when enabled.
    start_frame(8'hFF, 0);
    wait_drain("fFF");
    check_int("busy_fFF", busy_cnt, exp_ff);

    // Six 1s ending on the last bit: stuffing lands just before EOP.
    start_frame(8'hFC, 0);
    wait_drain("fFC");
    check_int("busy_fFC", busy_cnt, exp_fc);

    // Start pulse with new data in mid-DATA must be ignored; no second frame.
    start_frame(8'h3C, 4);
    repeat (10) @(posedge CLK);
    #2;
    in_data  = 8'hFF;
    in_start = 1'b1;
    @(posedge CLK);
    #2;
    in_start = 1'b0;
    wait_drain("ignore_start");
    check_int("busy_f3C", busy_cnt, SL + 8 + 3);

    // Reset during a frame, then an immediate clean frame.
    start_frame(8'h00, 0);
    repeat (8) @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    #1 check_idle("reset_mid_frame");
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    start_frame(8'hA5, 0);
    wait_drain("fA5");
    check_int("busy_fA5", busy_cnt, SL + 8 + 3);

    // in_start held: three back-to-back frames, one IDLE (done) cycle between.
    done_cnt = 0;
    in_data  = 8'h5A;
    in_start = 1'b1;
    sb.push_back(mk(0, 0, 1, 0, 0));
    for (int f = 0; f < 3; f++) push_frame(8'h5A);
    for (int i = 0; i < 3; i++) sb.push_back(mk(0, 0, 1, 0, 0));
    repeat (50) @(posedge CLK);
    #2;
    in_start = 1'b0;
    wait_drain("b2b");
    check_int("done_pulses", done_cnt, 3);
    check_idle("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
